// File: rtl/adaptive_threshold_pkg.sv
// rtl/adaptive_threshold_pkg.sv - shared types and defaults for the adaptive-threshold sequencer
// State encoding, address-width derivation and default drain/timeout lengths.
package adaptive_threshold_pkg;

  localparam int DEF_WIDTH_BITS   = 7;
  localparam int DEF_HEIGHT_BITS  = 7;
  localparam int DEF_DRAIN_CYCLES = 2;
  localparam int DEF_CNT_BITS     = 32;

  function automatic int addr_bits(input int width_bits, input int height_bits);
    return width_bits + height_bits;
  endfunction

  // One full frame of pixels plus a little slack for pipeline latency.
  function automatic int default_timeout(input int abits);
    return (1 << abits) + 64;
  endfunction

  localparam int DEF_ADDR_BITS      = addr_bits(DEF_WIDTH_BITS, DEF_HEIGHT_BITS);
  localparam int DEF_TIMEOUT_CYCLES = default_timeout(DEF_ADDR_BITS);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MEAN_RUN   = 3'd1,
    ST_MEAN_DRAIN = 3'd2,
    ST_BIN_RUN    = 3'd3,
    ST_BIN_DRAIN  = 3'd4,
    ST_DONE       = 3'd5,
    ST_ERROR      = 3'd6
  } state_e;

endpackage

// File: rtl/adaptive_threshold_sequencer_stage_watchdog.sv
// rtl/adaptive_threshold_sequencer_stage_watchdog.sv - shared run timeout and drain counters
// One instance serves both stages; only one stage is ever running or draining.
module stage_watchdog
  import adaptive_threshold_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int DRAIN_CYCLES   = DEF_DRAIN_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic tmo_clear,
  input  logic tmo_inc,
  input  logic drain_load,
  input  logic drain_dec,
  output logic tmo_expire,
  output logic drain_zero
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int DW = $clog2(DRAIN_CYCLES) + 1;

  logic [TW-1:0] tmo_q, tmo_d;
  logic [DW-1:0] drain_q, drain_d;

  always_comb begin
    tmo_d = tmo_q;
    if (tmo_clear) begin
      tmo_d = '0;
    end else if (tmo_inc && (tmo_q != '1)) begin
      tmo_d = tmo_q + 1'b1;
    end

    drain_d = drain_q;
    if (drain_load) begin
      drain_d = DW'(DRAIN_CYCLES - 1);
    end else if (drain_dec && (drain_q != '0)) begin
      drain_d = drain_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_q   <= '0;
      drain_q <= '0;
    end else begin
      tmo_q   <= tmo_d;
      drain_q <= drain_d;
    end
  end

  assign tmo_expire = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign drain_zero = (drain_q == '0);

endmodule

// File: rtl/adaptive_threshold_sequencer.sv
// rtl/adaptive_threshold_sequencer.sv - runs mean stage then binarize stage, owns shared memory ports
// Stage resets are decoded from next state so they change on the same edge as the state.
module adaptive_threshold_sequencer
  import adaptive_threshold_pkg::*;
#(
  parameter int WIDTH_BITS     = DEF_WIDTH_BITS,
  parameter int HEIGHT_BITS    = DEF_HEIGHT_BITS,
  parameter int ADDR_BITS      = addr_bits(WIDTH_BITS, HEIGHT_BITS),
  parameter int DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
  parameter int TIMEOUT_CYCLES = default_timeout(ADDR_BITS),
  parameter int CNT_BITS       = DEF_CNT_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iStart,
  input  logic                 iAbort,
  output logic                 oMeanReset,
  input  logic                 iMeanFinished,
  input  logic [ADDR_BITS-1:0] iMeanImgAddr,
  input  logic                 iMeanThrWren,
  output logic                 oBinReset,
  input  logic                 iBinFinished,
  input  logic [ADDR_BITS-1:0] iBinImgAddr,
  input  logic                 iBinResWren,
  output logic [ADDR_BITS-1:0] oImgAddr,
  output logic                 oThrWren,
  output logic                 oResWren,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oError,
  output logic [CNT_BITS-1:0]  oCycles
);

  state_e              state_q, state_d;
  logic                mean_reset_q, mean_reset_d;
  logic                bin_reset_q, bin_reset_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [CNT_BITS-1:0] cycles_q, cycles_d;

  logic tmo_expire, drain_zero;
  logic tmo_clear, tmo_inc, drain_load, drain_dec;
  logic mean_phase, bin_phase;

  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    error_d  = error_q;
    cycles_d = cycles_q;
    if (busy_q && (cycles_q != '1)) begin
      cycles_d = cycles_q + 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (iStart) begin
          state_d  = ST_MEAN_RUN;
          cycles_d = '0;
          done_d   = 1'b0;
          error_d  = 1'b0;
        end
      end
      ST_MEAN_RUN: begin
        if (iMeanFinished) begin
          state_d = ST_MEAN_DRAIN;
        end else if (tmo_expire) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end
      end
      ST_MEAN_DRAIN: begin
        if (drain_zero) state_d = ST_BIN_RUN;
      end
      ST_BIN_RUN: begin
        if (iBinFinished) begin
          state_d = ST_BIN_DRAIN;
        end else if (tmo_expire) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end
      end
      ST_BIN_DRAIN: begin
        if (drain_zero) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including a same-cycle start; counter and flags freeze.
    if (iAbort) begin
      state_d  = ST_IDLE;
      cycles_d = cycles_q;
      done_d   = done_q;
      error_d  = error_q;
    end

    mean_reset_d = !((state_d == ST_MEAN_RUN) || (state_d == ST_MEAN_DRAIN));
    bin_reset_d  = !((state_d == ST_BIN_RUN) || (state_d == ST_BIN_DRAIN));
    busy_d       = !mean_reset_d || !bin_reset_d;
  end

  always_comb begin
    tmo_clear  = ((state_d == ST_MEAN_RUN) && (state_q != ST_MEAN_RUN)) ||
                 ((state_d == ST_BIN_RUN) && (state_q != ST_BIN_RUN));
    tmo_inc    = (state_q == ST_MEAN_RUN) || (state_q == ST_BIN_RUN);
    drain_load = ((state_q == ST_MEAN_RUN) && (state_d == ST_MEAN_DRAIN)) ||
                 ((state_q == ST_BIN_RUN) && (state_d == ST_BIN_DRAIN));
    drain_dec  = (state_q == ST_MEAN_DRAIN) || (state_q == ST_BIN_DRAIN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mean_reset_q <= 1'b1;
      bin_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cycles_q     <= '0;
    end else begin
      state_q      <= state_d;
      mean_reset_q <= mean_reset_d;
      bin_reset_q  <= bin_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cycles_q     <= cycles_d;
    end
  end

  stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .DRAIN_CYCLES  (DRAIN_CYCLES)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .tmo_clear (tmo_clear),
    .tmo_inc   (tmo_inc),
    .drain_load(drain_load),
    .drain_dec (drain_dec),
    .tmo_expire(tmo_expire),
    .drain_zero(drain_zero)
  );

  assign mean_phase = (state_q == ST_MEAN_RUN) || (state_q == ST_MEAN_DRAIN);
  assign bin_phase  = (state_q == ST_BIN_RUN) || (state_q == ST_BIN_DRAIN);

  assign oImgAddr   = mean_phase ? iMeanImgAddr : (bin_phase ? iBinImgAddr : '0);
  assign oThrWren   = iMeanThrWren & mean_phase;
  assign oResWren   = iBinResWren & bin_phase;

  assign oMeanReset = mean_reset_q;
  assign oBinReset  = bin_reset_q;
  assign oBusy      = busy_q;
  assign oDone      = done_q;
  assign oError     = error_q;
  assign oCycles    = cycles_q;

endmodule

// File: tb/tb_adaptive_threshold_sequencer.sv
// tb/tb_adaptive_threshold_sequencer.sv - self-checking bench for adaptive_threshold_sequencer
// Stub stages finish a programmable number of cycles after their reset is released.
module tb_adaptive_threshold_sequencer;

  localparam int AB = 14;
  localparam int CB = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          iStart = 1'b0;
  logic          iAbort = 1'b0;
  logic          oMeanReset, oBinReset;
  logic          iMeanFinished, iBinFinished;
  logic [AB-1:0] iMeanImgAddr = '0;
  logic [AB-1:0] iBinImgAddr = '0;
  logic          iMeanThrWren = 1'b0;
  logic          iBinResWren = 1'b0;
  logic [AB-1:0] oImgAddr;
  logic          oThrWren, oResWren, oBusy, oDone, oError;
  logic [CB-1:0] oCycles;

  int mean_n = 4, bin_n = 4;
  bit mean_hang = 1'b0, bin_hang = 1'b0;
  int mean_cnt = 0, bin_cnt = 0;
  int mean_low_tot = 0, bin_low_tot = 0;
  int base_m = 0, base_b = 0;
  int checks = 0, passes = 0;

  typedef struct {
    string         name;
    bit            done;
    bit            err;
    logic [CB-1:0] cycles;
    int            mlow;
    int            blow;
  } run_t;
  run_t run_q[$];

  typedef struct {
    int            phase;
    logic [AB-1:0] ma, ba;
    logic          tw, rw;
    logic [AB-1:0] ea;
    logic          et, er;
  } vec_t;
  vec_t vecs[6];

  typedef struct {
    int            idx;
    logic [AB-1:0] a;
    logic          t, r;
  } mux_exp_t;
  mux_exp_t mux_q[$];

  adaptive_threshold_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .iStart       (iStart),
    .iAbort       (iAbort),
    .oMeanReset   (oMeanReset),
    .iMeanFinished(iMeanFinished),
    .iMeanImgAddr (iMeanImgAddr),
    .iMeanThrWren (iMeanThrWren),
    .oBinReset    (oBinReset),
    .iBinFinished (iBinFinished),
    .iBinImgAddr  (iBinImgAddr),
    .iBinResWren  (iBinResWren),
    .oImgAddr     (oImgAddr),
    .oThrWren     (oThrWren),
    .oResWren     (oResWren),
    .oBusy        (oBusy),
    .oDone        (oDone),
    .oError       (oError),
    .oCycles      (oCycles)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    mean_cnt <= (oMeanReset !== 1'b0) ? 0 : mean_cnt + 1;
    bin_cnt  <= (oBinReset !== 1'b0) ? 0 : bin_cnt + 1;
  end

  assign iMeanFinished = (oMeanReset === 1'b0) && !mean_hang && (mean_cnt >= mean_n - 1);
  assign iBinFinished  = (oBinReset === 1'b0) && !bin_hang && (bin_cnt >= bin_n - 1);

  always @(negedge clock) begin
    if (!reset) begin
      if (oMeanReset === 1'b0) mean_low_tot = mean_low_tot + 1;
      if (oBinReset === 1'b0) bin_low_tot = bin_low_tot + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic start_run();
    @(posedge clock);
    #1 iStart = 1'b1;
    base_m = mean_low_tot;
    base_b = bin_low_tot;
    @(posedge clock);
    #1 iStart = 1'b0;
  endtask

  task automatic finish_run(input int budget);
    bit   ok;
    run_t r;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (oDone || oError) begin
        ok = 1'b1;
        break;
      end
    end
    r = run_q.pop_front();
    check({r.name, "_ended"}, 64'(ok), 64'd1);
    check({r.name, "_done"}, 64'(oDone), 64'(r.done));
    check({r.name, "_error"}, 64'(oError), 64'(r.err));
    check({r.name, "_busy"}, 64'(oBusy), 64'd0);
    check({r.name, "_cycles"}, 64'(oCycles), 64'(r.cycles));
    check({r.name, "_mean_low"}, 64'(mean_low_tot - base_m), 64'(r.mlow));
    check({r.name, "_bin_low"}, 64'(bin_low_tot - base_b), 64'(r.blow));
  endtask

  task automatic wait_bin_run(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (oBinReset === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_reached_bin_run"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_finish_seen(input string name, input bit bin);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bin ? iBinFinished : iMeanFinished) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_finish_seen"}, 64'(ok), 64'd1);
  endtask

  initial begin
    int       phase;
    bit       ok;
    mux_exp_t m;

    vecs[0] = '{0, 14'h1234, 14'h2bcd, 1'b1, 1'b1, 14'h0000, 1'b0, 1'b0};
    vecs[1] = '{1, 14'h1234, 14'h0abc, 1'b1, 1'b1, 14'h1234, 1'b1, 1'b0};
    vecs[2] = '{1, 14'h3fff, 14'h0001, 1'b0, 1'b1, 14'h3fff, 1'b0, 1'b0};
    vecs[3] = '{2, 14'h1234, 14'h2bcd, 1'b1, 1'b1, 14'h2bcd, 1'b0, 1'b1};
    vecs[4] = '{2, 14'h0000, 14'h0555, 1'b1, 1'b0, 14'h0555, 1'b0, 1'b0};
    vecs[5] = '{3, 14'h1234, 14'h2bcd, 1'b1, 1'b1, 14'h0000, 1'b0, 1'b0};

    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check("rst_mean_reset", 64'(oMeanReset), 64'd1);
    check("rst_bin_reset", 64'(oBinReset), 64'd1);
    check("rst_busy", 64'(oBusy), 64'd0);
    check("rst_done", 64'(oDone), 64'd0);
    check("rst_error", 64'(oError), 64'd0);
    check("rst_cycles", 64'(oCycles), 64'd0);
    check("rst_img_addr", 64'(oImgAddr), 64'd0);

    // Start and abort together while idle: abort must win.
    @(posedge clock);
    #1 begin iStart = 1'b1; iAbort = 1'b1; end
    @(posedge clock);
    #1 begin iStart = 1'b0; iAbort = 1'b0; end
    @(negedge clock);
    check("start_abort_busy", 64'(oBusy), 64'd0);
    check("start_abort_mean_reset", 64'(oMeanReset), 64'd1);
    check("start_abort_cycles", 64'(oCycles), 64'd0);
    @(negedge clock);
    check("start_abort_busy_later", 64'(oBusy), 64'd0);

    // Mux gating table walked through IDLE, MEAN_RUN, BIN_RUN, DONE.
    mean_hang = 1'b1;
    bin_hang  = 1'b1;
    mean_n    = 4;
    bin_n     = 4;
    phase     = 0;
    for (int i = 0; i < 6; i++) begin
      while (phase < vecs[i].phase) begin
        phase++;
        iMeanThrWren = 1'b0;
        iBinResWren  = 1'b0;
        if (phase == 1) begin
          start_run();
        end else if (phase == 2) begin
          mean_hang = 1'b0;
          wait_bin_run("mux");
        end else begin
          bin_hang = 1'b0;
          ok = 1'b0;
          for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (oDone) begin ok = 1'b1; break; end
          end
          check("mux_reached_done", 64'(ok), 64'd1);
        end
      end
      @(posedge clock);
      #1 begin
        iMeanImgAddr = vecs[i].ma;
        iBinImgAddr  = vecs[i].ba;
        iMeanThrWren = vecs[i].tw;
        iBinResWren  = vecs[i].rw;
        mux_q.push_back('{i, vecs[i].ea, vecs[i].et, vecs[i].er});
      end
      #1 begin
        m = mux_q.pop_front();
        check($sformatf("mux%0d_img_addr", m.idx), 64'(oImgAddr), 64'(m.a));
        check($sformatf("mux%0d_thr_wren", m.idx), 64'(oThrWren), 64'(m.t));
        check($sformatf("mux%0d_res_wren", m.idx), 64'(oResWren), 64'(m.r));
      end
    end
    iMeanThrWren = 1'b0;
    iBinResWren  = 1'b0;
    iMeanImgAddr = '0;
    iBinImgAddr  = '0;

    // Full-size run: each stub finishes after 16384 cycles, 2 drain cycles each.
    mean_n = 16384;
    bin_n  = 16384;
    run_q.push_back('{"full", 1'b1, 1'b0, 32'd32772, 16386, 16386});
    start_run();
    finish_run(40000);

    // Abort in BIN_RUN three cycles after it is entered.
    mean_n   = 4;
    bin_n    = 4;
    bin_hang = 1'b1;
    start_run();
    wait_bin_run("abort");
    check("abort_cycles_at_bin_entry", 64'(oCycles), 64'd6);
    check("abort_mean_low", 64'(mean_low_tot - base_m), 64'd6);
    repeat (3) @(posedge clock);
    #1 iAbort = 1'b1;
    @(posedge clock);
    #1 iAbort = 1'b0;
    @(negedge clock);
    check("abort_mean_reset", 64'(oMeanReset), 64'd1);
    check("abort_bin_reset", 64'(oBinReset), 64'd1);
    check("abort_busy", 64'(oBusy), 64'd0);
    check("abort_done", 64'(oDone), 64'd0);
    check("abort_cycles_frozen", 64'(oCycles), 64'd9);
    repeat (3) @(negedge clock);
    check("abort_cycles_still_frozen", 64'(oCycles), 64'd9);
    bin_hang = 1'b0;

    // Start pulses in MEAN_RUN and BIN_DRAIN are ignored.
    mean_n = 8;
    bin_n  = 8;
    run_q.push_back('{"ignore_start", 1'b1, 1'b0, 32'd20, 10, 10});
    start_run();
    repeat (3) @(posedge clock);
    #1 iStart = 1'b1;
    @(posedge clock);
    #1 iStart = 1'b0;
    wait_finish_seen("ignore_bin", 1'b1);
    @(posedge clock);
    #1 iStart = 1'b1;
    @(posedge clock);
    #1 iStart = 1'b0;
    finish_run(200);

    // Mean stage never finishes: timeout after 16448 RUN cycles, then restart clears error.
    mean_n    = 4;
    mean_hang = 1'b1;
    run_q.push_back('{"timeout", 1'b0, 1'b1, 32'd16448, 16448, 0});
    start_run();
    finish_run(17000);
    check("timeout_mean_reset", 64'(oMeanReset), 64'd1);
    start_run();
    @(negedge clock);
    check("restart_error_cleared", 64'(oError), 64'd0);
    check("restart_busy", 64'(oBusy), 64'd1);
    check("restart_mean_reset", 64'(oMeanReset), 64'd0);
    @(posedge clock);
    #1 iAbort = 1'b1;
    @(posedge clock);
    #1 iAbort = 1'b0;
    mean_hang = 1'b0;

    // Asynchronous reset in MEAN_DRAIN, away from any clock edge, then a clean rerun.
    mean_n = 4;
    bin_n  = 4;
    start_run();
    wait_finish_seen("areset", 1'b0);
    @(posedge clock);
    #3 reset = 1'b1;
    #1 begin
      check("areset_mean_reset", 64'(oMeanReset), 64'd1);
      check("areset_bin_reset", 64'(oBinReset), 64'd1);
      check("areset_busy", 64'(oBusy), 64'd0);
      check("areset_done", 64'(oDone), 64'd0);
      check("areset_error", 64'(oError), 64'd0);
      check("areset_cycles", 64'(oCycles), 64'd0);
    end
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    run_q.push_back('{"rerun", 1'b1, 1'b0, 32'd12, 6, 6});
    start_run();
    finish_run(200);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/adaptive_threshold_sequencer.md
Name: adaptive_threshold_sequencer

Overview:
Top-level controller for the adaptive-thresholding pipeline. It runs two stage modules in order: the mean/threshold-compute stage (writes the threshold memory) and the binarize stage (threshold image vs. threshold memory, writes the result memory). Each stage is started by releasing its active-high reset and is judged complete by its `finished` flag. The sequencer also owns the shared image-memory read address and gates the memory write enables so only the active stage can drive them.

Parameters:
- WIDTH_BITS, 7, log2 of image width.
- HEIGHT_BITS, 7, log2 of image height.
- ADDR_BITS, WIDTH_BITS+HEIGHT_BITS, packed pixel address width {row,col}.
- DRAIN_CYCLES, 2, cycles held after a stage's `finished` so its last write lands (min 1).
- TIMEOUT_CYCLES, 2**(ADDR_BITS)+64, maximum cycles per RUN state before error.
- CNT_BITS, 32, width of the performance counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  async active-high reset.
- iStart  in  1  start pulse, sampled only in IDLE/DONE/ERROR.
- iAbort  in  1  abort, any state.
- oMeanReset  out  1  reset to mean stage, high = held.
- iMeanFinished  in  1  mean stage finished flag.
- iMeanImgAddr  in  ADDR_BITS  mean stage image read address.
- iMeanThrWren  in  1  mean stage threshold-mem write enable.
- oBinReset  out  1  reset to binarize stage.
- iBinFinished  in  1  binarize stage finished flag.
- iBinImgAddr  in  ADDR_BITS  binarize stage image read address.
- iBinResWren  in  1  binarize stage result-mem write enable.
- oImgAddr  out  ADDR_BITS  muxed image-memory read address.
- oThrWren  out  1  gated threshold-mem write enable.
- oResWren  out  1  gated result-mem write enable.
- oBusy  out  1  pipeline running.
- oDone  out  1  last run completed.
- oError  out  1  last run timed out.
- oCycles  out  CNT_BITS  cycles spent busy in last/current run.

Behaviour:
- Clock is `clock`. Reset `reset` is asynchronous, active-high. All state and registered outputs are asynchronously cleared or set by it.
- Reset values: state=IDLE, oMeanReset=1, oBinReset=1, oBusy=0, oDone=0, oError=0, oCycles=0, timeout counter=0, drain counter=0.
- States: IDLE, MEAN_RUN, MEAN_DRAIN, BIN_RUN, BIN_DRAIN, DONE, ERROR.
- IDLE/DONE/ERROR, with iStart=1 and iAbort=0 at an edge:
  - Next state MEAN_RUN.
  - oCycles, oDone, oError cleared.
  - oBusy=1.
  - Effect visible the cycle after the edge (1-cycle latency).
- MEAN_RUN:
  - iMeanFinished=1 → MEAN_DRAIN, drain counter loaded with DRAIN_CYCLES-1.
  - Otherwise, timeout counter reaching TIMEOUT_CYCLES-1 → ERROR.
  - If finished and timeout occur in the same cycle, finished wins.
- MEAN_DRAIN: counts down; at 0 → BIN_RUN, timeout counter cleared.
- BIN_RUN / BIN_DRAIN: identical rules using iBinFinished; BIN_DRAIN at 0 → DONE.
- DONE: oDone=1, oBusy=0. Stays until iStart or reset.
- ERROR: oError=1, oBusy=0. Stays until iStart or reset.
- iAbort=1 in any state → IDLE next cycle. Both stage resets high, oBusy=0, oDone/oError unchanged, oCycles frozen. Abort beats a simultaneous start.
- Stage resets are registered and decoded from next-state:
  - oMeanReset=0 exactly while state ∈ {MEAN_RUN, MEAN_DRAIN}.
  - oBinReset=0 exactly while state ∈ {BIN_RUN, BIN_DRAIN}.
  - Stages are always re-held in reset ≥1 cycle before any rerun.
- Timeout counter increments every RUN cycle and saturates. It is cleared on entry to each RUN state.
- oCycles increments every cycle oBusy=1 and saturates at all-ones.
- Combinational muxes (no added latency):
  - oImgAddr = iMeanImgAddr in MEAN_*, iBinImgAddr in BIN_*, else 0.
  - oThrWren = iMeanThrWren & (state ∈ MEAN_*).
  - oResWren = iBinResWren & (state ∈ BIN_*).
- iStart while busy is ignored (no queueing).

Decomposition:
- Shared package `adaptive_threshold_pkg`:
  - State enum localparams (3-bit encoding).
  - ADDR_BITS derivation.
  - Default DRAIN_CYCLES/TIMEOUT_CYCLES.
- One natural sub-module: `stage_watchdog`. It holds the saturating timeout counter and drain down-counter, with load/clear/expire outputs, and is instantiated once and shared across both stages.
- FSM, reset decode and muxes stay in the top module.

Test Plan:
1. Stub stages assert finished 16384 cycles after reset release (DRAIN_CYCLES=2), iStart pulse → oMeanReset low 16386 cycles, then oBinReset low 16386 cycles, oDone=1, oBusy=0, oCycles=32772.
2. Mean stub never finishes → ERROR after TIMEOUT_CYCLES=16448 RUN cycles, oError=1, oMeanReset=1; iStart → restarts, oError=0.
3. iAbort mid BIN_RUN → next cycle IDLE, both resets=1, oBusy=0, oDone=0, oCycles frozen at abort value.
4. iStart pulses during MEAN_RUN and BIN_DRAIN → no effect on state or oCycles; iStart+iAbort together in IDLE → remains IDLE.
5. Mux gating: iBinResWren=1 during MEAN_RUN → oResWren=0; iMeanImgAddr=0x1234 in MEAN_RUN → oImgAddr=0x1234; in DONE → oImgAddr=0.
6. Async reset asserted mid MEAN_DRAIN (not on a clock edge) → all outputs at reset values immediately; rerun after release completes normally.
